// File: rtl/seg7_scan_decoder.sv
// ============================================================================
// Module   : seg7_scan_decoder
// Brief    : Scans a multiplexed 4-digit 7-segment bus and decodes each digit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_decoder #(
    parameter int SETTLE = 4,
    parameter int STABLE = 3,
    parameter int MAXTRY = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        na,
    input  logic        nb,
    input  logic        nc,
    input  logic        nd,
    input  logic        ne,
    input  logic        nf,
    input  logic        ng,
    output logic [3:0]  ndig,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        lt,
    output logic        frame_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_digit;
    logic [3:0]  r_cnt;
    logic [3:0]  r_match;
    logic [7:0]  r_tries;
    logic [6:0]  r_last;

    logic [3:0]  r_res_code;
    logic        r_res_blank;
    logic        r_res_err;
    logic        r_res_lt;

    logic [15:0] r_sh_value;
    logic [3:0]  r_sh_blank;
    logic [3:0]  r_sh_err;
    logic [3:0]  r_sh_lt;

    logic [6:0]  w_seg;
    logic [3:0]  w_code;
    logic        w_blank;
    logic        w_err;
    logic [3:0]  w_match_nxt;
    logic [7:0]  w_tries_nxt;
    logic [1:0]  w_digit_inc;

    assign w_seg       = {na, nb, nc, nd, ne, nf, ng};
    assign w_match_nxt = (r_match == 4'd0 || w_seg != r_last) ? 4'd1 : r_match + 4'd1;
    assign w_tries_nxt = r_tries + 8'd1;
    assign w_digit_inc = r_digit + 2'd1;

    always_comb begin
        w_code  = 4'h0;
        w_blank = 1'b0;
        w_err   = 1'b0;
        case (w_seg)
            7'b0000001: w_code = 4'h0;
            7'b1001111: w_code = 4'h1;
            7'b0010010: w_code = 4'h2;
            7'b0000110: w_code = 4'h3;
            7'b1001100: w_code = 4'h4;
            7'b0100100: w_code = 4'h5;
            7'b1100000: w_code = 4'h6;
            7'b0001111: w_code = 4'h7;
            7'b0000000: w_code = 4'h8;
            7'b0001100: w_code = 4'h9;
            7'b1110010: w_code = 4'hA;
            7'b1100110: w_code = 4'hB;
            7'b1011100: w_code = 4'hC;
            7'b0110100: w_code = 4'hD;
            7'b1110000: w_code = 4'hE;
            7'b1111111: w_blank = 1'b1;
            default:    w_err   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_digit     <= 2'd0;
            r_cnt       <= 4'd0;
            r_match     <= 4'd0;
            r_tries     <= 8'd0;
            r_last      <= 7'd0;
            r_res_code  <= 4'd0;
            r_res_blank <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_lt    <= 1'b0;
            r_sh_value  <= 16'd0;
            r_sh_blank  <= 4'd0;
            r_sh_err    <= 4'd0;
            r_sh_lt     <= 4'd0;
            ndig        <= 4'b1111;
            value       <= 16'd0;
            blank       <= 4'd0;
            err         <= 4'd0;
            lt          <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (!en) begin
                // Abort: partial frame is dropped, published outputs are kept.
                r_state    <= S_IDLE;
                r_digit    <= 2'd0;
                r_cnt      <= 4'd0;
                r_match    <= 4'd0;
                r_tries    <= 8'd0;
                r_sh_value <= 16'd0;
                r_sh_blank <= 4'd0;
                r_sh_err   <= 4'd0;
                r_sh_lt    <= 4'd0;
                ndig       <= 4'b1111;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_SETTLE;
                        r_digit <= 2'd0;
                        r_cnt   <= 4'd0;
                        ndig    <= 4'b1110;
                    end
                    S_SETTLE: begin
                        if (r_cnt == 4'(SETTLE - 1)) begin
                            r_state <= S_SAMPLE;
                            r_match <= 4'd0;
                            r_tries <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_SAMPLE: begin
                        r_last  <= w_seg;
                        r_match <= w_match_nxt;
                        r_tries <= w_tries_nxt;
                        // Stability wins over the try budget on the same sample.
                        if (w_match_nxt == 4'(STABLE)) begin
                            r_state     <= S_COMMIT;
                            r_res_code  <= w_code;
                            r_res_blank <= w_blank;
                            r_res_err   <= w_err;
                            r_res_lt    <= (w_seg == 7'b0000000);
                        end else if (w_tries_nxt == 8'(MAXTRY)) begin
                            r_state     <= S_COMMIT;
                            r_res_code  <= 4'd0;
                            r_res_blank <= 1'b0;
                            r_res_err   <= 1'b1;
                            r_res_lt    <= 1'b0;
                        end
                    end
                    S_COMMIT: begin
                        r_sh_value[{r_digit, 2'b00} +: 4] <= r_res_code;
                        r_sh_blank[r_digit] <= r_res_blank;
                        r_sh_err[r_digit]   <= r_res_err;
                        r_sh_lt[r_digit]    <= r_res_lt;
                        if (r_digit == 2'd3) begin
                            value       <= {r_res_code, r_sh_value[11:0]};
                            blank       <= {r_res_blank, r_sh_blank[2:0]};
                            err         <= {r_res_err, r_sh_err[2:0]};
                            lt          <= r_res_lt & (&r_sh_lt[2:0]);
                            frame_valid <= 1'b1;
                        end
                        r_digit <= w_digit_inc;
                        r_cnt   <= 4'd0;
                        r_state <= S_SETTLE;
                        ndig    <= ~(4'b0001 << w_digit_inc);
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
